// File: rtl/seg_pkg.sv
// ============================================================================
// Module : seg_pkg
// Brief  : Shared constants and types for the 7-segment scanner and decoder.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_pkg;

    localparam int DIGIT_W = 4;

    // Nibble bit carried by each decoder input line
    localparam int NIB_A = 3;
    localparam int NIB_B = 2;
    localparam int NIB_C = 1;
    localparam int NIB_D = 0;

    localparam int TICK_DIV_DEF  = 4;
    localparam int BLANK_CYC_DEF = 1;

    typedef struct packed {
        logic               dp;
        logic [DIGIT_W-1:0] val;
    } digit_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg_scan_div.sv
// ============================================================================
// Module : seg_scan_div
// Brief  : Slot prescaler: cnt counts cycles within a digit slot, idx selects
//          the digit; frame strobes on the last cycle of the last slot.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_div #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 4,
    parameter int CNT_W    = 2,
    parameter int IDX_W    = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] o_cnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_frame
);

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] c_idx_max = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             w_adv;

    assign w_adv = (r_cnt == c_cnt_max);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            r_cnt <= w_adv ? '0 : r_cnt + CNT_W'(1);
            if (w_adv) begin
                r_idx <= (r_idx == c_idx_max) ? '0 : r_idx + IDX_W'(1);
            end
        end
    end

    assign o_cnt   = r_cnt;
    assign o_idx   = r_idx;
    assign o_frame = w_adv && (r_idx == c_idx_max);

endmodule

`default_nettype wire

// File: rtl/seg_scan.sv
// ============================================================================
// Module : seg_scan
// Brief  : Time-multiplexed digit scanner with frame-synchronous double
//          buffering and leading-zero blanking, feeding the seg decoder.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan
    import seg_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int TICK_DIV  = TICK_DIV_DEF,
    parameter int BLANK_CYC = BLANK_CYC_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DIGIT_W*DIGITS-1:0] din,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  lz_en,
    output logic                  a,
    output logic                  b,
    output logic                  c,
    output logic                  d,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);

    localparam int c_cnt_w = $clog2(TICK_DIV);
    localparam int c_idx_w = idx_width(DIGITS);
    localparam logic [DIGITS-1:0] c_an_lsb = DIGITS'(1);

    logic [c_cnt_w-1:0]        w_cnt;
    logic [c_idx_w-1:0]        w_idx;
    logic                      w_frame;

    digit_t [DIGITS-1:0]       r_active;
    digit_t [DIGITS-1:0]       r_shadow;
    logic                      r_pending;
    digit_t [DIGITS-1:0]       w_load_word;

    logic [DIGITS:1]           w_zero_up;
    logic [DIGITS-1:0]         w_dark;
    logic                      w_blank_slot;
    digit_t                    w_cur;
    logic [DIGITS-1:0]         w_an;
    logic                      w_dp;

    seg_scan_div #(
        .DIGITS   (DIGITS),
        .TICK_DIV (TICK_DIV),
        .CNT_W    (c_cnt_w),
        .IDX_W    (c_idx_w)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .o_cnt   (w_cnt),
        .o_idx   (w_idx),
        .o_frame (w_frame)
    );

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_pack
            assign w_load_word[k].dp  = dp_in[k];
            assign w_load_word[k].val = din[DIGIT_W*k +: DIGIT_W];
        end
    endgenerate

    // A load on the swap edge lands in shadow and keeps pending for next frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active  <= '0;
            r_shadow  <= '0;
            r_pending <= 1'b0;
        end else begin
            if (w_frame && r_pending) begin
                r_active <= r_shadow;
            end
            if (load) begin
                r_shadow  <= w_load_word;
                r_pending <= 1'b1;
            end else if (w_frame && r_pending) begin
                r_pending <= 1'b0;
            end
        end
    end

    // w_zero_up[k]: active digits k..DIGITS-1 are all zero
    assign w_zero_up[DIGITS] = 1'b1;
    assign w_dark[0]         = 1'b0;
    generate
        for (genvar k = 1; k < DIGITS; k++) begin : g_lz
            assign w_zero_up[k] = (r_active[k].val == '0) && w_zero_up[k+1];
            assign w_dark[k]    = lz_en && w_zero_up[k];
        end
    endgenerate

    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign w_blank_slot = 1'b0;
        end else begin : g_blank
            assign w_blank_slot = (w_cnt < c_cnt_w'(BLANK_CYC));
        end
    endgenerate

    always_comb begin
        w_cur = r_active[w_idx];
        w_an  = '0;
        w_dp  = 1'b0;
        if (!w_blank_slot && !w_dark[w_idx]) begin
            w_an = c_an_lsb << w_idx;
            w_dp = w_cur.dp;
        end
    end

    assign a     = w_cur.val[NIB_A];
    assign b     = w_cur.val[NIB_B];
    assign c     = w_cur.val[NIB_C];
    assign d     = w_cur.val[NIB_D];
    assign an    = w_an;
    assign dp    = w_dp;
    assign frame = w_frame;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan.sv
// ============================================================================
// Module : tb_seg_scan
// Brief  : Directed bench for seg_scan (DIGITS=4, TICK_DIV=4, BLANK_CYC=1).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] din = '0;
    logic [3:0]  dp_in = '0;
    logic        lz_en = 1'b0;
    logic        a, b, c, d, dp, frame;
    logic [3:0]  an;

    int tests = 0;
    int fails = 0;

    seg_scan #(
        .DIGITS    (4),
        .TICK_DIV  (4),
        .BLANK_CYC (1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .din   (din),
        .dp_in (dp_in),
        .lz_en (lz_en),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .dp    (dp),
        .an    (an),
        .frame (frame)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        ld;
        logic [15:0] dv;
        logic [3:0]  pv;
        logic        lz;
        int          n;
        logic        chk;
        logic [3:0]  e_an;
        logic [3:0]  e_abcd;
        logic        e_dp;
        logic        e_fr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, ld, input logic [15:0] dv,
                                input logic [3:0] pv, input logic lz, input int n,
                                input logic chk, input logic [3:0] e_an, e_abcd,
                                input logic e_dp, e_fr);
        vec_t v;
        v.r = r; v.ld = ld; v.dv = dv; v.pv = pv; v.lz = lz; v.n = n;
        v.chk = chk; v.e_an = e_an; v.e_abcd = e_abcd; v.e_dp = e_dp; v.e_fr = e_fr;
        return v;
    endfunction

    // One clock cycle: drive inputs just after the edge, check at negedge.
    task automatic cyc(input logic r, ld, input logic [15:0] dv, input logic [3:0] pv,
                       input logic lz, input logic chk, input logic [3:0] e_an, e_abcd,
                       input logic e_dp, e_fr, input string nm);
        rst = r; load = ld; din = dv; dp_in = pv; lz_en = lz;
        @(negedge clk);
        if (chk) begin
            tests++;
            if (an !== e_an || {a, b, c, d} !== e_abcd || dp !== e_dp || frame !== e_fr) begin
                fails++;
                $display("FAIL %s: got an=%b abcd=%b dp=%b frame=%b, expected an=%b abcd=%b dp=%b frame=%b",
                         nm, an, {a, b, c, d}, dp, frame, e_an, e_abcd, e_dp, e_fr);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic lz);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0, 4'h0, lz, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, "idle");
    endtask

    task automatic chk(input logic lz, input logic [3:0] e_an, e_abcd, input logic e_dp, e_fr,
                       input string nm);
        cyc(1'b0, 1'b0, 16'h0, 4'h0, lz, 1'b1, e_an, e_abcd, e_dp, e_fr, nm);
    endtask

    task automatic ld(input logic [15:0] dv, input logic [3:0] pv);
        cyc(1'b0, 1'b1, dv, pv, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, "load");
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, "rst");
    endtask

    initial begin
        // reset hold with load asserted, then the 1234 frame, then lz on 0070
        vecs.push_back(mk(1, 1, 16'hFFFF, 4'hF, 0, 5, 1, 4'b0000, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0,    4'h0, 0, 1, 1, 4'b0000, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0,    4'h0, 0, 1, 1, 4'b0001, 4'h0, 0, 0));
        vecs.push_back(mk(0, 1, 16'h1234, 4'h0, 0, 1, 1, 4'b0001, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0,    4'h0, 0, 1, 1, 4'b0001, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0,    4'h0, 0, 1, 1, 4'b0000, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0,    4'h0, 0, 3, 1, 4'b0010, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0,    4'h0, 0, 1, 1, 4'b0000, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0,    4'h0, 0, 3, 1, 4'b0100, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0,    4'h0, 0, 1, 1, 4'b0000, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0,    4'h0, 0, 2, 1, 4'b1000, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0,    4'h0, 0, 1, 1, 4'b1000, 4'h0, 0, 1));
        vecs.push_back(mk(0, 0, 16'h0,    4'h0, 0, 1, 1, 4'b0000, 4'h4, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0,    4'h0, 0, 3, 1, 4'b0001, 4'h4, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0,    4'h0, 0, 1, 1, 4'b0000, 4'h3, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0,    4'h0, 0, 3, 1, 4'b0010, 4'h3, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0,    4'h0, 0, 1, 1, 4'b0000, 4'h2, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0,    4'h0, 0, 3, 1, 4'b0100, 4'h2, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0,    4'h0, 0, 1, 1, 4'b0000, 4'h1, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0,    4'h0, 0, 2, 1, 4'b1000, 4'h1, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0,    4'h0, 0, 1, 1, 4'b1000, 4'h1, 0, 1));
        vecs.push_back(mk(0, 1, 16'h0070, 4'h0, 1, 1, 0, 4'b0000, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0,    4'h0, 1, 15, 0, 4'b0000, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0,    4'h0, 1, 1, 1, 4'b0000, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0,    4'h0, 1, 3, 1, 4'b0001, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0,    4'h0, 1, 1, 1, 4'b0000, 4'h7, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0,    4'h0, 1, 3, 1, 4'b0010, 4'h7, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0,    4'h0, 1, 4, 1, 4'b0000, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0,    4'h0, 1, 3, 1, 4'b0000, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0,    4'h0, 1, 1, 1, 4'b0000, 4'h0, 0, 1));
        vecs.push_back(mk(0, 0, 16'h0,    4'h0, 1, 8, 0, 4'b0000, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0,    4'h0, 0, 1, 1, 4'b0000, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0,    4'h0, 0, 3, 1, 4'b0100, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0,    4'h0, 1, 3, 1, 4'b0000, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0,    4'h0, 1, 1, 1, 4'b0000, 4'h0, 0, 1));

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            for (int j = 0; j < vecs[i].n; j++) begin
                cyc(vecs[i].r, vecs[i].ld, vecs[i].dv, vecs[i].pv, vecs[i].lz, vecs[i].chk,
                    vecs[i].e_an, vecs[i].e_abcd, vecs[i].e_dp, vecs[i].e_fr,
                    $sformatf("vec%0d.%0d", i, j));
            end
        end

        // last load in a frame wins
        do_reset();
        idle(3, 0); ld(16'h1111, 4'h0); idle(5, 0); ld(16'h2222, 4'h0); idle(7, 0);
        chk(0, 4'b0001, 4'h2, 0, 0, "last_wins_d0");
        idle(3, 0);
        chk(0, 4'b0010, 4'h2, 0, 0, "last_wins_d1");
        idle(7, 0);
        chk(0, 4'b1000, 4'h2, 0, 0, "last_wins_d3");

        // load on the swap edge stays pending for one more frame
        do_reset();
        idle(3, 0); ld(16'h1111, 4'h0); idle(11, 0);
        cyc(1'b0, 1'b1, 16'h5555, 4'h0, 1'b0, 1'b1, 4'b1000, 4'h0, 1'b0, 1'b1, "swap_edge_load");
        idle(1, 0);
        chk(0, 4'b0001, 4'h1, 0, 0, "swap_edge_old");
        idle(13, 0);
        chk(0, 4'b1000, 4'h1, 0, 1, "swap_edge_old_d3");
        idle(1, 0);
        chk(0, 4'b0001, 4'h5, 0, 0, "swap_edge_new");

        // decimal point on digit 1, then suppressed by leading-zero blanking
        do_reset();
        ld(16'h0000, 4'b0010); idle(15, 0);
        chk(0, 4'b0000, 4'h0, 0, 0, "dp_blank_d0");
        chk(0, 4'b0001, 4'h0, 0, 0, "dp_d0");
        idle(2, 0);
        chk(0, 4'b0000, 4'h0, 0, 0, "dp_blank_d1");
        chk(0, 4'b0010, 4'h0, 1, 0, "dp_d1_a");
        chk(0, 4'b0010, 4'h0, 1, 0, "dp_d1_b");
        idle(1, 0);
        chk(0, 4'b0000, 4'h0, 0, 0, "dp_blank_d2");
        chk(0, 4'b0100, 4'h0, 0, 0, "dp_d2");
        idle(7, 0);
        chk(1, 4'b0001, 4'h0, 0, 0, "lz_d0_kept");
        idle(3, 1);
        chk(1, 4'b0000, 4'h0, 0, 0, "lz_dp_suppressed");

        // mid-frame reset discards active and pending data
        do_reset();
        ld(16'h1234, 4'h0); idle(19, 0); ld(16'h5678, 4'h0); idle(4, 0);
        cyc(1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 1'b1, 4'b0100, 4'h2, 1'b0, 1'b0, "pre_reset");
        chk(0, 4'b0000, 4'h0, 0, 0, "post_reset_c0");
        chk(0, 4'b0001, 4'h0, 0, 0, "post_reset_c1");
        idle(13, 0);
        chk(0, 4'b1000, 4'h0, 0, 1, "post_reset_frame");
        idle(1, 0);
        chk(0, 4'b0001, 4'h0, 0, 0, "post_reset_no_pending_d0");
        idle(3, 0);
        chk(0, 4'b0010, 4'h0, 0, 0, "post_reset_no_pending_d1");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Time-multiplexed digit scanner directly upstream of the `seg` 7-segment decoder.
- Holds DIGITS 4-bit digit values plus decimal points.
- Each digit is presented in turn on the nibble outputs a,b,c,d, which feed `seg` a,b,c,d one-to-one, with a one-hot digit enable.
- New display data is double-buffered and swapped only at frame boundaries, so a frame never mixes old and new data.

Parameters:
- DIGITS, 4: number of digits scanned; digit 0 is least significant.
- TICK_DIV, 4: clock cycles each digit is held; legal values ≥2.
- BLANK_CYC, 1: cycles at the start of each digit slot with all enables off (anti-ghosting); legal range 0..TICK_DIV-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- load  in  1  capture din/dp_in into the shadow buffer.
- din  in  4*DIGITS  digit values; din[4k+3:4k] is digit k.
- dp_in  in  DIGITS  decimal point per digit; bit k is digit k.
- lz_en  in  1  leading-zero blanking enable.
- a  out  1  nibble bit 3 (MSB) to decoder.
- b  out  1  nibble bit 2.
- c  out  1  nibble bit 1.
- d  out  1  nibble bit 0 (LSB).
- dp  out  1  decimal point for the currently enabled digit.
- an  out  DIGITS  one-hot digit enable, active-high.
- frame  out  1  one-cycle pulse on the last cycle of each frame.

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high.
- State held in registers:
  - cnt: 0..TICK_DIV-1.
  - idx: 0..DIGITS-1.
  - active buffer and shadow buffer, each DIGITS×(4+1) bits.
  - pending flag.
- Reset state:
  - cnt=0, idx=0, active=0, shadow=0, pending=0.
  - Outputs: a=b=c=d=0, dp=0, an=0, frame=0.
  - Reset asserted mid-frame discards any pending data. The first cycle after release is cnt=0, idx=0.
- Prescaler:
  - cnt increments every cycle and wraps from TICK_DIV-1 to 0.
  - On the wrap, idx increments and wraps from DIGITS-1 to 0.
- All outputs are combinational from registered state, with no extra latency.
  - Nibble outputs: {a,b,c,d} = active digit[idx].
  - Values 10..15 pass through unmodified.
- Enables:
  - an = 0 while cnt < BLANK_CYC; otherwise an = one-hot(idx).
  - dp = active dp[idx] whenever an != 0; otherwise dp = 0.
- frame = 1 exactly when cnt==TICK_DIV-1 and idx==DIGITS-1.
- Load:
  - On an edge with load=1: shadow <= {dp_in, din} and pending <= 1.
  - Multiple loads within one frame: the last one wins.
- Swap: on the edge where frame=1 and pending=1:
  - active <= shadow (the value held before that edge).
  - pending <= 0, unless load=1 in the same cycle. In that case the new data enters shadow, pending stays 1, and it is displayed one frame later.
- Leading-zero blanking: digit k (k≥1) is dark (an=0, dp=0) when all of the following hold:
  - lz_en=1;
  - active digit k = 0;
  - every more-significant active digit = 0.
  - Digit 0 is never blanked.
  - A set dp on a blanked digit is suppressed.
  - lz_en is sampled live, with no buffering.
- Nibble outputs still show the digit value while the enable is off.

Decomposition:
- seg_pkg holds:
  - DIGIT_W=4.
  - Nibble-to-bit mapping (a=bit3 … d=bit0).
  - Default TICK_DIV/BLANK_CYC constants, shared with the decoder bench.
- One sub-module, seg_scan_div: cnt/idx prescaler producing the digit-advance and frame strobes.
- Buffering, blanking and output muxing stay in seg_scan.

Test Plan (DIGITS=4, TICK_DIV=4, BLANK_CYC=1; cycle 0 = first cycle after rst release):
1. Hold rst for 5 cycles with load=1 and din=16'hFFFF → an=0, abcd=0, dp=0, frame=0 throughout. After release, cycle 0 has idx=0 and active=0.
2. load=1 with din=16'h1234 at cycle 2, lz_en=0:
   - Cycles 1–3 show an=0001 with abcd=0000; frame=1 at cycle 15.
   - Cycle 16: an=0.
   - Cycles 17–19: an=0001 with abcd=0100.
   - Cycles 21–23: an=0010 with abcd=0011.
   - Cycles 29–31: an=1000 with abcd=0001.
3. lz_en=1, din=16'h0070 loaded and swapped in → an never shows 1000 or 0100; digit 1 shows 0111 with an=0010; digit 0 shows 0000 with an=0001.
4. Load 16'h1111 at cycle 3, then 16'h2222 at cycle 9 → frame from cycle 16 shows only 2. A separate load 16'h5555 at cycle 15 (the swap edge) → pending stays 1; 5s appear from cycle 32.
5. dp_in=4'b0010 loaded → dp=1 only during cycles with an=0010; dp=0 in every blank cycle.
6. rst asserted at cycle 25 (idx=2) for 1 cycle → next cycle has an=0 and abcd=0; scan restarts at idx=0; previously loaded data is gone and pending=0.
